// File: rtl/joypad_ps2_pkg.sv
// Shared constants for the PS/2-keyboard-to-NES-joypad bridge: scancodes, prefixes,
// button bit positions, CPU register addresses and decoder state encoding.
package joypad_ps2_pkg;

  localparam logic [7:0] ScA      = 8'h1A;
  localparam logic [7:0] ScB      = 8'h22;
  localparam logic [7:0] ScSelect = 8'h21;
  localparam logic [7:0] ScStart  = 8'h5A;
  localparam logic [7:0] ScUp     = 8'h75;
  localparam logic [7:0] ScDown   = 8'h72;
  localparam logic [7:0] ScLeft   = 8'h6B;
  localparam logic [7:0] ScRight  = 8'h74;

  localparam logic [7:0] PfxExt = 8'hE0;
  localparam logic [7:0] PfxBrk = 8'hF0;

  localparam int unsigned BtnA      = 0;
  localparam int unsigned BtnB      = 1;
  localparam int unsigned BtnSelect = 2;
  localparam int unsigned BtnStart  = 3;
  localparam int unsigned BtnUp     = 4;
  localparam int unsigned BtnDown   = 5;
  localparam int unsigned BtnLeft   = 6;
  localparam int unsigned BtnRight  = 7;

  localparam logic [15:0] AddrPad1 = 16'h4016;
  localparam logic [15:0] AddrPad2 = 16'h4017;

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} dec_state_e;

  // One-hot button mask for a scancode; extended codes only match after an E0 prefix.
  function automatic logic [7:0] btn_mask(input logic [7:0] code, input logic ext);
    logic [7:0] m;
    m = '0;
    if (!ext) begin
      case (code)
        ScA:      m[BtnA]      = 1'b1;
        ScB:      m[BtnB]      = 1'b1;
        ScSelect: m[BtnSelect] = 1'b1;
        ScStart:  m[BtnStart]  = 1'b1;
        default:  ;
      endcase
    end else begin
      case (code)
        ScUp:    m[BtnUp]    = 1'b1;
        ScDown:  m[BtnDown]  = 1'b1;
        ScLeft:  m[BtnLeft]  = 1'b1;
        ScRight: m[BtnRight] = 1'b1;
        default: ;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronisers, falling-edge sampling, 11-bit frame shifter and
// inactivity resync. Define JOYPAD_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_rx #(
  parameter int unsigned TIMEOUT = 25000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       byte_valid,
  output logic [7:0] rx_byte
);

`ifdef JOYPAD_PARITY_CHECK_EN
  localparam bit ParityCheck = 1'b1;
`else
  localparam bit ParityCheck = 1'b0;
`endif

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic          clk_s1_q, clk_s2_q, clk_prev_q;
  logic          dat_s1_q, dat_s2_q;
  logic [3:0]    bit_cnt_q;
  logic [9:0]    shift_q;
  logic [TW-1:0] idle_q;
  logic          valid_q;
  logic [7:0]    byte_q;

  logic          fall;
  logic [10:0]   frame;
  logic          accept;

  assign fall  = clk_prev_q & ~clk_s2_q;
  // Frame as it will look once the bit being sampled now is shifted in.
  assign frame = {dat_s2_q, shift_q};
  assign accept = ~frame[0] & frame[10] & (^frame[9:1] | ~ParityCheck);

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      idle_q     <= '0;
      valid_q    <= 1'b0;
      byte_q     <= '0;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_dat;
      dat_s2_q   <= dat_s1_q;
      valid_q    <= 1'b0;
      if (fall) begin
        idle_q  <= '0;
        shift_q <= frame[10:1];
        if (bit_cnt_q == 4'd10) begin
          bit_cnt_q <= '0;
          if (accept) begin
            valid_q <= 1'b1;
            byte_q  <= frame[8:1];
          end
        end else begin
          bit_cnt_q <= bit_cnt_q + 4'd1;
        end
      end else if (idle_q == TW'(TIMEOUT)) begin
        bit_cnt_q <= '0;
      end else begin
        idle_q <= idle_q + 1'b1;
      end
    end
  end

  assign byte_valid = valid_q;
  assign rx_byte    = byte_q;

endmodule

// File: rtl/joypad_ps2.sv
// NES-style joypad at $4016/$4017 driven from a PS/2 keyboard.
// Optional JOYPAD_PARITY_CHECK_EN enables parity rejection in the receiver.
module joypad_ps2
  import joypad_ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT = 25000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  input  logic [15:0] addr,
  input  logic [7:0]  din,
  input  logic        wr,
  input  logic        rd,
  output logic [7:0]  q,
  output logic [7:0]  buttons
);

  logic       byte_valid;
  logic [7:0] rx_byte;

  dec_state_e state_q, state_d;
  logic [7:0] btn_set, btn_clr;
  logic [7:0] buttons_q;
  logic [7:0] shift_q;
  logic       strobe_q;
  logic       pad_wr, pad_rd;
  logic       unused_din;

  ps2_rx #(
    .TIMEOUT(TIMEOUT)
  ) u_rx (
    .clock     (clock),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .byte_valid(byte_valid),
    .rx_byte   (rx_byte)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (byte_valid) begin
      if (rx_byte == PfxExt)                          state_d = StExt;
      else if (rx_byte == PfxBrk && state_q == StIdle) state_d = StBrk;
      else if (rx_byte == PfxBrk && state_q == StExt)  state_d = StExtBrk;
      else                                             state_d = StIdle;
    end
  end

  // Any byte that returns the decoder to idle is a make/break code for the current state.
  always_comb begin
    btn_set = '0;
    btn_clr = '0;
    if (byte_valid && state_d == StIdle) begin
      unique case (state_q)
        StIdle:   btn_set = btn_mask(rx_byte, 1'b0);
        StExt:    btn_set = btn_mask(rx_byte, 1'b1);
        StBrk:    btn_clr = btn_mask(rx_byte, 1'b0);
        StExtBrk: btn_clr = btn_mask(rx_byte, 1'b1);
      endcase
    end
  end

  assign pad_wr     = wr && (addr == AddrPad1);
  assign pad_rd     = rd && (addr == AddrPad1);
  assign unused_din = ^din[7:1];

  // Reload uses buttons_q, so a key event in the same clock is seen one clock later.
  always_ff @(posedge clock) begin
    if (reset) begin
      buttons_q <= '0;
      shift_q   <= 8'hFF;
      strobe_q  <= 1'b0;
    end else begin
      buttons_q <= (buttons_q | btn_set) & ~btn_clr;
      if (pad_wr) strobe_q <= din[0];
      if (strobe_q)                shift_q <= buttons_q;
      else if (pad_rd && !pad_wr)  shift_q <= {1'b1, shift_q[7:1]};
    end
  end

  always_comb begin
    q = 8'h00;
    if (addr == AddrPad1)      q = {7'b0100000, shift_q[0]};
    else if (addr == AddrPad2) q = 8'h40;
  end

  assign buttons = buttons_q;

endmodule

// File: tb/tb_joypad_ps2.sv
// Scoreboard bench for joypad_ps2: stimulus queues expectations, the monitor pops and
// compares them whenever the CPU reads or a button check is requested.
module tb_joypad_ps2;

  localparam int unsigned TIMEOUT = 200;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [15:0] addr = '0;
  logic [7:0]  din = '0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [7:0]  q;
  logic [7:0]  buttons;

  logic chk_btn = 1'b0;
  logic drain = 1'b0;

  typedef struct {
    bit         is_btn;
    logic [7:0] exp;
    string      name;
  } chk_t;

  chk_t sb[$];
  chk_t mon_c;
  logic [7:0] mon_act;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  joypad_ps2 #(
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .ps2_clk(ps2_clk),
    .ps2_dat(ps2_dat),
    .addr   (addr),
    .din    (din),
    .wr     (wr),
    .rd     (rd),
    .q      (q),
    .buttons(buttons)
  );

  always @(negedge clock) begin
    if (rd || chk_btn) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got q=%h buttons=%h, required a queued expectation",
                 q, buttons);
      end else begin
        mon_c   = sb.pop_front();
        mon_act = mon_c.is_btn ? buttons : q;
        checks++;
        if (mon_act !== mon_c.exp) begin
          errors++;
          $display("FAIL %s: got %h, required %h", mon_c.name, mon_act, mon_c.exp);
        end
      end
    end
    if (drain) begin
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL drain: got %0d pending expectations, required 0", sb.size());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    tick(8);
    ps2_clk = 1'b0;
    tick(8);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    ps2_dat = 1'b1;
    tick(10);
  endtask

  task automatic expect_btn(input logic [7:0] v, input string name);
    sb.push_back('{1'b1, v, name});
    chk_btn = 1'b1;
    tick(1);
    chk_btn = 1'b0;
  endtask

  task automatic cpu_rd(input logic [15:0] a, input logic [7:0] exp, input string name);
    addr = a;
    rd   = 1'b1;
    sb.push_back('{1'b0, exp, name});
    tick(1);
    rd   = 1'b0;
    addr = '0;
  endtask

  task automatic cpu_wr(input logic [7:0] d);
    addr = 16'h4016;
    din  = d;
    wr   = 1'b1;
    tick(1);
    wr   = 1'b0;
    addr = '0;
  endtask

  task automatic cpu_wrrd(input logic [7:0] d, input logic [7:0] exp, input string name);
    addr = 16'h4016;
    din  = d;
    wr   = 1'b1;
    rd   = 1'b1;
    sb.push_back('{1'b0, exp, name});
    tick(1);
    wr   = 1'b0;
    rd   = 1'b0;
    addr = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
  endtask

  logic [9:0] seq_bits;

  initial begin
    seq_bits = 10'b1100001001;  // bit0 first: 1,0,0,1,0,0,0,0,1,1
    do_reset();
    expect_btn(8'h00, "reset_buttons");
    cpu_rd(16'h4016, 8'h41, "reset_q4016");
    cpu_rd(16'h4017, 8'h40, "q4017");
    cpu_rd(16'h1234, 8'h00, "q_other");

    send_frame(8'h1A, 1'b0, 11);
    expect_btn(8'h01, "make_a");
    send_frame(8'hF0, 1'b0, 11);
    send_frame(8'h1A, 1'b0, 11);
    expect_btn(8'h00, "break_a");

    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'h75, 1'b0, 11);
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'h6B, 1'b0, 11);
    expect_btn(8'h50, "make_up_left");
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'hF0, 1'b0, 11);
    send_frame(8'h75, 1'b0, 11);
    expect_btn(8'h40, "break_up");

    do_reset();
    send_frame(8'h1A, 1'b0, 11);
    send_frame(8'h5A, 1'b0, 11);
    expect_btn(8'h09, "make_a_start");
    cpu_wr(8'h01);
    tick(2);
    cpu_wr(8'h00);
    for (int i = 0; i < 10; i++) cpu_rd(16'h4016, {7'b0100000, seq_bits[i]}, "serial_read");
    cpu_wr(8'h01);
    tick(1);
    cpu_wr(8'h00);
    cpu_wrrd(8'h00, 8'h41, "wr_rd_same_clock");
    cpu_rd(16'h4016, 8'h41, "no_shift_on_wr");
    cpu_rd(16'h4016, 8'h40, "shift_after_wr");
    cpu_rd(16'h4017, 8'h40, "q4017_no_state");
    cpu_rd(16'h4016, 8'h40, "after_4017_read");

    do_reset();
    send_frame(8'h1A, 1'b1, 11);
`ifdef JOYPAD_PARITY_CHECK_EN
    expect_btn(8'h00, "bad_parity");
`else
    expect_btn(8'h01, "bad_parity");
`endif

    do_reset();
    send_frame(8'h3C, 1'b0, 5);
    tick(TIMEOUT + 20);
    send_frame(8'h22, 1'b0, 11);
    expect_btn(8'h02, "timeout_resync");

    send_frame(8'h1A, 1'b0, 6);
    do_reset();
    expect_btn(8'h00, "midframe_reset_buttons");
    cpu_rd(16'h4016, 8'h41, "midframe_reset_q");
    send_frame(8'h5A, 1'b0, 11);
    expect_btn(8'h08, "frame_after_reset");

    tick(2);
    drain = 1'b1;
    tick(1);
    drain = 1'b0;
    tick(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL sim_timeout: got no completion, required completion within time limit");
    $fatal(1, "time limit");
  end

endmodule
